fic0_ahb_arbiter: RTL

- Shares the single FIC_0 AHB-Lite user master port into the HPMS between two fabric requesters: requester 0 is the SD-card data mover and requester 1 is the control/config engine.
- Issues one single-beat, 32-bit, non-locked transfer at a time.
- Handles HREADY wait states and the HRESP error response.
- Returns read data and status to the granted requester as a one-cycle ack.

---
 rtl/fic0_ahb_arbiter.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/fic0_ahb_arbiter.sv
// Two-requester arbiter sharing the FIC_0 AHB-Lite master port; one single-beat transfer at a time.
// Optional macro FIC0_ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins) instead of round-robin.
module fic0_ahb_arbiter #(
    parameter logic [3:0]  HPROT_VAL = 4'b0011,
    parameter int unsigned NREQ      = 2
) (
    input  logic            FPGA_CLK,
    input  logic            reset,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] req_write,
    input  logic [31:0]     req_addr0,
    input  logic [31:0]     req_addr1,
    input  logic [31:0]     req_wdata0,
    input  logic [31:0]     req_wdata1,
    output logic [NREQ-1:0] ack,
    output logic [31:0]     rdata,
    output logic            err,
    output logic            gnt_id,
    output logic            busy,
    output logic [31:0]     HADDR,
    output logic [1:0]      HTRANS,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic            HMASTLOCK,
    output logic [31:0]     HWDATA,
    input  logic            HREADY,
    input  logic [1:0]      HRESP,
    input  logic [31:0]     HRDATA
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   haddr_q, haddr_d;
    logic [1:0]      htrans_q, htrans_d;
    logic            hwrite_q, hwrite_d;
    logic [DW-1:0]   hwdata_q, hwdata_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic            gnt_id_q, gnt_id_d;
`ifndef FIC0_ARB_FIXED_PRIO_EN
    logic            rr_q, rr_d;
`endif

    logic [NREQ-1:0] req_m;
    logic            grant_v;
    logic            gnt_sel;
    logic            unused_ok;

    assign unused_ok = ^{req_addr0[1:0], req_addr1[1:0], HRESP[1]};

    // Winner selection; a requester is masked during its own ack cycle.
    always_comb begin
        req_m = req & ~ack_q;
`ifdef FIC0_ARB_FIXED_PRIO_EN
        // Requester 1 must not slip in while requester 0 is only hidden by its ack mask.
        grant_v = req_m[0] || (req_m[1] && !req[0]);
        gnt_sel = !req_m[0];
`else
        grant_v = |req_m;
        gnt_sel = (&req_m) ? ~rr_q : req_m[1];
`endif
    end

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        ack_d    = '0;
        rdata_d  = '0;
        err_d    = 1'b0;
        busy_d   = busy_q;
        gnt_id_d = gnt_id_q;
`ifndef FIC0_ARB_FIXED_PRIO_EN
        rr_d     = rr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_v) begin
                    haddr_d  = {(gnt_sel ? req_addr1[AW-1:2] : req_addr0[AW-1:2]), 2'b00};
                    hwrite_d = req_write[gnt_sel];
                    wdata_d  = gnt_sel ? req_wdata1 : req_wdata0;
                    htrans_d = HTRANS_NONSEQ;
                    gnt_id_d = gnt_sel;
                    busy_d   = 1'b1;
`ifndef FIC0_ARB_FIXED_PRIO_EN
                    rr_d     = gnt_sel;
`endif
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (HREADY) begin
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = wdata_q;
                    state_d  = ST_DATA;
                end
            end
            ST_DATA: begin
                // An ERROR response completes only on its HREADY=1 cycle.
                if (HREADY) begin
                    ack_d[gnt_id_q] = 1'b1;
                    rdata_d         = hwrite_q ? '0 : HRDATA;
                    err_d           = HRESP[0];
                    busy_d          = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                htrans_d = HTRANS_IDLE;
                busy_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge FPGA_CLK) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            wdata_q  <= '0;
            ack_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            gnt_id_q <= 1'b0;
`ifndef FIC0_ARB_FIXED_PRIO_EN
            rr_q     <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            ack_q    <= ack_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            gnt_id_q <= gnt_id_d;
`ifndef FIC0_ARB_FIXED_PRIO_EN
            rr_q     <= rr_d;
`endif
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HWDATA    = hwdata_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VAL;
    assign HMASTLOCK = 1'b0;
    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_id_q;

endmodule
